// File: rtl/seg7_time_display.sv
// MM.SS time display for a 4-digit common-anode 7-segment panel.
// Samples sec/min once per scan frame, converts them to BCD serially, and multiplexes the digits.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a frame boundary to snapshot sec/min
// CONV_SEC | repeated-subtract-10 on the seconds snapshot
// CONV_MIN | repeated-subtract-10 on the minutes snapshot
// COMMIT   | copy all four BCD nibbles into the display registers at once
module seg7_time_display #(
   parameter int REFRESH_DIV = 100000,
   parameter bit DP_SEP      = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] sec,
   input  logic [5:0] min,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp
);

   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CONV_SEC = 2'd1,
      S_CONV_MIN = 2'd2,
      S_COMMIT   = 2'd3
   } state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [PW-1:0]   r_presc;
   logic [1:0]      r_digit;
   logic            w_tick;
   logic            w_frame;
   logic [5:0]      r_sec_snap;
   logic [5:0]      r_min_snap;
   logic [2:0]      r_tens;
   logic [3:0]      r_sec_ones;
   logic [3:0]      r_sec_tens;
   logic [3:0]      r_min_ones;
   logic [3:0]      r_min_tens;
   logic [15:0]     r_disp;
   logic [3:0]      w_nib;
   logic [6:0]      w_seg;
   logic [3:0]      w_an;
   logic            w_dp;

   assign w_tick  = (r_presc == PW'(REFRESH_DIV - 1));
   assign w_frame = w_tick && (r_digit == 2'd3);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_presc <= '0;
         r_digit <= 2'd0;
      end else if (w_tick) begin
         r_presc <= '0;
         r_digit <= r_digit + 2'd1;
      end else begin
         r_presc <= r_presc + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:     if (w_frame) w_state_nxt = S_CONV_SEC;
         S_CONV_SEC: if (r_sec_snap < 6'd10) w_state_nxt = S_CONV_MIN;
         S_CONV_MIN: if (r_min_snap < 6'd10) w_state_nxt = S_COMMIT;
         S_COMMIT:   w_state_nxt = S_IDLE;
         default:    w_state_nxt = S_IDLE;
      endcase
   end

   // The snapshot registers double as the working values during conversion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sec_snap <= 6'd0;
         r_min_snap <= 6'd0;
         r_tens     <= 3'd0;
         r_sec_ones <= 4'd0;
         r_sec_tens <= 4'd0;
         r_min_ones <= 4'd0;
         r_min_tens <= 4'd0;
         r_disp     <= 16'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_frame) begin
                  r_sec_snap <= sec;
                  r_min_snap <= min;
                  r_tens     <= 3'd0;
               end
            end
            S_CONV_SEC: begin
               if (r_sec_snap >= 6'd10) begin
                  r_sec_snap <= r_sec_snap - 6'd10;
                  r_tens     <= r_tens + 3'd1;
               end else begin
                  r_sec_tens <= {1'b0, r_tens};
                  r_sec_ones <= r_sec_snap[3:0];
                  r_tens     <= 3'd0;
               end
            end
            S_CONV_MIN: begin
               if (r_min_snap >= 6'd10) begin
                  r_min_snap <= r_min_snap - 6'd10;
                  r_tens     <= r_tens + 3'd1;
               end else begin
                  r_min_tens <= {1'b0, r_tens};
                  r_min_ones <= r_min_snap[3:0];
                  r_tens     <= 3'd0;
               end
            end
            S_COMMIT: begin
               r_disp <= {r_min_tens, r_min_ones, r_sec_tens, r_sec_ones};
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_nib = 4'd0;
      case (r_digit)
         2'd0: w_nib = r_disp[3:0];
         2'd1: w_nib = r_disp[7:4];
         2'd2: w_nib = r_disp[11:8];
         2'd3: w_nib = r_disp[15:12];
         default: w_nib = 4'd0;
      endcase
   end

   // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles blank the digit.
   always_comb begin
      w_seg = 7'b1111111;
      case (w_nib)
         4'd0: w_seg = 7'b1000000;
         4'd1: w_seg = 7'b1111001;
         4'd2: w_seg = 7'b0100100;
         4'd3: w_seg = 7'b0110000;
         4'd4: w_seg = 7'b0011001;
         4'd5: w_seg = 7'b0010010;
         4'd6: w_seg = 7'b0000010;
         4'd7: w_seg = 7'b1111000;
         4'd8: w_seg = 7'b0000000;
         4'd9: w_seg = 7'b0010000;
         default: w_seg = 7'b1111111;
      endcase
   end

   assign w_an = ~(4'b0001 << r_digit);
   assign w_dp = !(DP_SEP && (r_digit == 2'd2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an  <= 4'b1111;
         seg <= 7'b1111111;
         dp  <= 1'b1;
      end else begin
         an  <= w_an;
         seg <= w_seg;
         dp  <= w_dp;
      end
   end

endmodule

// File: tb/tb_seg7_time_display.sv
// Scoreboard bench for seg7_time_display: a cycle-level reference model of the
// displayed MM.SS value feeds a queue that a negedge monitor drains and compares.
module tb_seg7_time_display;

   localparam int R = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] sec;
   logic [5:0] min;
   logic [3:0] an,  an2;
   logic [6:0] seg, seg2;
   logic       dp,  dp2;

   int total = 0;
   int bad   = 0;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
   } exp_t;

   exp_t sb_q[$];

   int n         = 0;
   int cur_s     = 0;
   int cur_m     = 0;
   int pend_s    = 0;
   int pend_m    = 0;
   int commit_at = -1;

   always #5 clk = ~clk;

   seg7_time_display #(.REFRESH_DIV(R), .DP_SEP(1'b1)) u_dut (
      .clk(clk), .reset(reset), .sec(sec), .min(min),
      .an(an), .seg(seg), .dp(dp)
   );

   seg7_time_display #(.REFRESH_DIV(R), .DP_SEP(1'b0)) u_dut_nodp (
      .clk(clk), .reset(reset), .sec(sec), .min(min),
      .an(an2), .seg(seg2), .dp(dp2)
   );

   function automatic logic [6:0] seg_of(input int v);
      case (v)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Reference model: edge n after reset release shows digit ((n-1)/R)%4 of the
   // value on display before that edge; a capture at every 4R-th edge becomes
   // visible in the display registers after one cycle per subtract-or-latch
   // step for each field plus one commit cycle.
   always @(posedge clk) begin
      if (!reset) begin
         n         = 0;
         cur_s     = 0;
         cur_m     = 0;
         commit_at = -1;
      end else begin
         int   d;
         int   v;
         exp_t e;
         n = n + 1;
         d = ((n - 1) / R) % 4;
         case (d)
            0: v = cur_s % 10;
            1: v = cur_s / 10;
            2: v = cur_m % 10;
            default: v = cur_m / 10;
         endcase
         e.an  = ~(4'(1 << d));
         e.seg = seg_of(v);
         e.dp  = (d == 2) ? 1'b0 : 1'b1;
         sb_q.push_back(e);
         if (n == commit_at) begin
            cur_s     = pend_s;
            cur_m     = pend_m;
            commit_at = -1;
         end
         if ((n % (4 * R)) == 0 && commit_at < 0) begin
            pend_s    = int'(sec);
            pend_m    = int'(min);
            commit_at = n + (pend_s / 10 + 1) + (pend_m / 10 + 1) + 1;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         sb_q.delete();
         total = total + 1;
         if ({an, seg, dp, an2, seg2, dp2} !== {4'b1111, 7'b1111111, 1'b1, 4'b1111, 7'b1111111, 1'b1}) begin
            bad = bad + 1;
            $display("FAIL reset_hold t=%0t got an=%b seg=%b dp=%b an2=%b seg2=%b dp2=%b want 1111/1111111/1",
                     $time, an, seg, dp, an2, seg2, dp2);
         end
      end else if (sb_q.size() > 0) begin
         exp_t e;
         e = sb_q.pop_front();
         total = total + 1;
         if ({an, seg, dp, an2, seg2, dp2} !== {e.an, e.seg, e.dp, e.an, e.seg, 1'b1}) begin
            bad = bad + 1;
            $display("FAIL scan n=%0d t=%0t got an=%b seg=%b dp=%b dp_off_dut=%b/%b/%b want an=%b seg=%b dp=%b dp_off=1",
                     n, $time, an, seg, dp, an2, seg2, dp2, e.an, e.seg, e.dp);
         end
      end
   end

   task automatic check_reset_now(input string nm);
      #1;
      total = total + 1;
      if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
         bad = bad + 1;
         $display("FAIL %s got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", nm, an, seg, dp);
      end
   endtask

   initial begin
      reset = 1'b0;
      sec   = 6'd0;
      min   = 6'd0;
      repeat (3) @(posedge clk);
      check_reset_now("reset_async_hold");
      @(negedge clk);
      #2 reset = 1'b1;
      repeat (3 * 4 * R) @(negedge clk);

      sec = 6'd37; min = 6'd12;
      repeat (3 * 4 * R) @(negedge clk);
      repeat (5) @(negedge clk);
      sec = 6'd38;
      repeat (3 * 4 * R) @(negedge clk);

      sec = 6'd59; min = 6'd63;
      repeat (3 * 4 * R) @(negedge clk);

      // Restart, then hit reset while the minutes field is converting.
      @(posedge clk);
      #3 reset = 1'b0;
      check_reset_now("reset_async_idle");
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (24) @(posedge clk);
      #3 reset = 1'b0;
      check_reset_now("reset_during_conv_min");
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      repeat (4 * 4 * R) @(negedge clk);

      for (int i = 0; i < 40; i++) begin
         sec = 6'($urandom_range(0, 63));
         min = 6'($urandom_range(0, 63));
         repeat ($urandom_range(1, 40)) @(negedge clk);
      end
      repeat (4 * 4 * R) @(negedge clk);

      #1;
      total = total + 1;
      if (sb_q.size() != 0) begin
         bad = bad + 1;
         $display("FAIL sb_drain got %0d pending want 0", sb_q.size());
      end
      total = total + 1;
      if (total < 500) begin
         bad = bad + 1;
         $display("FAIL check_volume got %0d comparisons want >= 500", total);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
